// File: rtl/cpu_pipeline_pkg.sv
// Shared definitions for the cpu_pipeline front-end: opcode/function constants,
// control encodings and the per-stage control bundle types.
package cpu_pipeline_pkg;

    // Primary opcodes, instruction[31:26]
    localparam logic [5:0] OP_ARITH = 6'h02;
    localparam logic [5:0] OP_LDIL  = 6'h08;
    localparam logic [5:0] OP_LDO   = 6'h0D;
    localparam logic [5:0] OP_LDB   = 6'h10;
    localparam logic [5:0] OP_LDH   = 6'h11;
    localparam logic [5:0] OP_LDW   = 6'h12;
    localparam logic [5:0] OP_STB   = 6'h18;
    localparam logic [5:0] OP_STH   = 6'h19;
    localparam logic [5:0] OP_STW   = 6'h1A;
    localparam logic [5:0] OP_COMBT = 6'h20;
    localparam logic [5:0] OP_COMBF = 6'h22;
    localparam logic [5:0] OP_SUBI  = 6'h25;
    localparam logic [5:0] OP_ADDI  = 6'h2D;
    localparam logic [5:0] OP_EXTRU = 6'h34;
    localparam logic [5:0] OP_ZDEP  = 6'h35;
    localparam logic [5:0] OP_EXTRS = 6'h36;
    localparam logic [5:0] OP_BL    = 6'h3A;

    // Function field, instruction[11:6], valid only under OP_ARITH
    localparam logic [5:0] FN_AND  = 6'h08;
    localparam logic [5:0] FN_OR   = 6'h09;
    localparam logic [5:0] FN_XOR  = 6'h0A;
    localparam logic [5:0] FN_SUB  = 6'h10;
    localparam logic [5:0] FN_SUBB = 6'h14;
    localparam logic [5:0] FN_ADD  = 6'h18;
    localparam logic [5:0] FN_ADDC = 6'h1C;
    localparam logic [5:0] FN_ADDL = 6'h28;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_ADDC   = 4'b0001,
        ALU_SUB    = 4'b0010,
        ALU_SUBB   = 4'b0011,
        ALU_OR     = 4'b0100,
        ALU_XOR    = 4'b0101,
        ALU_AND    = 4'b0110,
        ALU_ADDL   = 4'b0111,
        ALU_PASS_B = 4'b1000,
        ALU_CMP    = 4'b1001
    } alu_op_e;

    typedef enum logic [2:0] {
        SOH_REG   = 3'b000,
        SOH_IM11  = 3'b001,
        SOH_IM14  = 3'b010,
        SOH_IM21  = 3'b011,
        SOH_EXTRU = 3'b100,
        SOH_EXTRS = 3'b101,
        SOH_ZDEP  = 3'b110
    } soh_op_e;

    // RAM_CTRL = {enable, write, size[1:0]}
    localparam logic [3:0] RAM_NONE = 4'b0000;
    localparam logic [3:0] RAM_LDB  = 4'b1000;
    localparam logic [3:0] RAM_LDH  = 4'b1001;
    localparam logic [3:0] RAM_LDW  = 4'b1010;
    localparam logic [3:0] RAM_STB  = 4'b1100;
    localparam logic [3:0] RAM_STH  = 4'b1101;
    localparam logic [3:0] RAM_STW  = 4'b1110;

    localparam logic [1:0] SRD_R3   = 2'b00;
    localparam logic [1:0] SRD_R2   = 2'b01;
    localparam logic [1:0] SRD_R1   = 2'b10;

    localparam logic [1:0] PSW_NONE = 2'b00;
    localparam logic [1:0] PSW_UPD  = 2'b10;
    localparam logic [1:0] PSW_RDUP = 2'b11;

    localparam logic [1:0] IDSR_NONE  = 2'b00;
    localparam logic [1:0] IDSR_STORE = 2'b01;
    localparam logic [1:0] IDSR_COMB  = 2'b10;

    typedef struct packed {
        logic [1:0] srd;
        logic [1:0] psw_le_re;
        logic       b;
        soh_op_e    soh_op;
        alu_op_e    alu_op;
        logic [3:0] ram_ctrl;
        logic       l;
        logic       rf_le;
        logic [1:0] id_sr;
        logic       ub;
    } ctrl_bundle_t;

    typedef struct packed {
        logic [3:0] ram_ctrl;
        logic       l;
        logic       rf_le;
    } mem_ctrl_t;

    localparam ctrl_bundle_t CTRL_NOP = '0;

    typedef logic [255:0][7:0] rom_image_t;
    localparam rom_image_t ROM_EMPTY = '0;

endpackage

// File: rtl/cpu_pipeline_if.sv
// Observation bundle of the pipeline: freeze/NOP controls in, PC, IF/ID word
// and every stage's control signals out.
interface cpu_pipeline_if;
    logic        LE;
    logic        S;
    logic [7:0]  front_q_out;
    logic [31:0] instruction_out;

    logic [1:0]  SRD_out;
    logic [1:0]  PSW_LE_RE_out;
    logic        B_out;
    logic [2:0]  SOH_OP_out;
    logic [3:0]  ALU_OP_out;
    logic [3:0]  RAM_CTRL_out;
    logic        L_out;
    logic        RF_LE_out;
    logic [1:0]  ID_SR_out;
    logic        UB_out;

    logic [1:0]  SRD_EX_out;
    logic [1:0]  PSW_LE_RE_EX_out;
    logic        B_EX_out;
    logic [2:0]  SOH_OP_EX_out;
    logic [3:0]  ALU_OP_EX_out;
    logic [3:0]  RAM_CTRL_EX_out;
    logic        L_EX_out;
    logic        RF_LE_EX_out;
    logic [1:0]  ID_SR_EX_out;
    logic        UB_EX_out;

    logic [3:0]  RAM_CTRL_MEM_out;
    logic        L_MEM_out;
    logic        RF_LE_MEM_out;
    logic        RF_LE_WB_out;

    // No handshake: LE and S are level controls sampled every cycle; all
    // outputs are valid continuously and carry no back-pressure.
    modport master (
        output LE, S,
        input  front_q_out, instruction_out,
        input  SRD_out, PSW_LE_RE_out, B_out, SOH_OP_out, ALU_OP_out,
        input  RAM_CTRL_out, L_out, RF_LE_out, ID_SR_out, UB_out,
        input  SRD_EX_out, PSW_LE_RE_EX_out, B_EX_out, SOH_OP_EX_out, ALU_OP_EX_out,
        input  RAM_CTRL_EX_out, L_EX_out, RF_LE_EX_out, ID_SR_EX_out, UB_EX_out,
        input  RAM_CTRL_MEM_out, L_MEM_out, RF_LE_MEM_out, RF_LE_WB_out
    );

    modport slave (
        input  LE, S,
        output front_q_out, instruction_out,
        output SRD_out, PSW_LE_RE_out, B_out, SOH_OP_out, ALU_OP_out,
        output RAM_CTRL_out, L_out, RF_LE_out, ID_SR_out, UB_out,
        output SRD_EX_out, PSW_LE_RE_EX_out, B_EX_out, SOH_OP_EX_out, ALU_OP_EX_out,
        output RAM_CTRL_EX_out, L_EX_out, RF_LE_EX_out, ID_SR_EX_out, UB_EX_out,
        output RAM_CTRL_MEM_out, L_MEM_out, RF_LE_MEM_out, RF_LE_WB_out
    );
endinterface

// File: rtl/cpu_pipeline_control_unit.sv
// Purely combinational decoder from opcode/function field to the control
// bundle; anything not recognised decodes as an all-zero NOP.
module cpu_control_unit
    import cpu_pipeline_pkg::*;
(
    input  logic [5:0]   opcode_i,
    input  logic [5:0]   func_i,
    output ctrl_bundle_t ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_NOP;
        case (opcode_i)
            OP_ARITH: begin
                ctrl_o.srd   = SRD_R3;
                ctrl_o.rf_le = 1'b1;
                case (func_i)
                    FN_ADD:  begin ctrl_o.alu_op = ALU_ADD;  ctrl_o.psw_le_re = PSW_UPD;  end
                    FN_ADDC: begin ctrl_o.alu_op = ALU_ADDC; ctrl_o.psw_le_re = PSW_RDUP; end
                    FN_SUB:  begin ctrl_o.alu_op = ALU_SUB;  ctrl_o.psw_le_re = PSW_UPD;  end
                    FN_SUBB: begin ctrl_o.alu_op = ALU_SUBB; ctrl_o.psw_le_re = PSW_RDUP; end
                    FN_OR:   ctrl_o.alu_op = ALU_OR;
                    FN_XOR:  ctrl_o.alu_op = ALU_XOR;
                    FN_AND:  ctrl_o.alu_op = ALU_AND;
                    FN_ADDL: ctrl_o.alu_op = ALU_ADDL;
                    default: ctrl_o = CTRL_NOP;
                endcase
            end
            OP_ADDI, OP_SUBI: begin
                ctrl_o.srd       = SRD_R2;
                ctrl_o.soh_op    = SOH_IM11;
                ctrl_o.alu_op    = (opcode_i == OP_ADDI) ? ALU_ADD : ALU_SUB;
                ctrl_o.psw_le_re = PSW_UPD;
                ctrl_o.rf_le     = 1'b1;
            end
            OP_LDW, OP_LDH, OP_LDB: begin
                ctrl_o.srd    = SRD_R2;
                ctrl_o.soh_op = SOH_IM14;
                ctrl_o.alu_op = ALU_ADD;
                ctrl_o.l      = 1'b1;
                ctrl_o.rf_le  = 1'b1;
                ctrl_o.ram_ctrl = (opcode_i == OP_LDW) ? RAM_LDW :
                                  (opcode_i == OP_LDH) ? RAM_LDH : RAM_LDB;
            end
            OP_STW, OP_STH, OP_STB: begin
                ctrl_o.soh_op = SOH_IM14;
                ctrl_o.alu_op = ALU_ADD;
                ctrl_o.id_sr  = IDSR_STORE;
                ctrl_o.ram_ctrl = (opcode_i == OP_STW) ? RAM_STW :
                                  (opcode_i == OP_STH) ? RAM_STH : RAM_STB;
            end
            OP_LDO: begin
                ctrl_o.srd    = SRD_R2;
                ctrl_o.soh_op = SOH_IM14;
                ctrl_o.alu_op = ALU_ADD;
                ctrl_o.rf_le  = 1'b1;
            end
            OP_LDIL: begin
                ctrl_o.srd    = SRD_R1;
                ctrl_o.soh_op = SOH_IM21;
                ctrl_o.alu_op = ALU_PASS_B;
                ctrl_o.rf_le  = 1'b1;
            end
            OP_EXTRU, OP_EXTRS, OP_ZDEP: begin
                ctrl_o.srd    = SRD_R2;
                ctrl_o.alu_op = ALU_PASS_B;
                ctrl_o.rf_le  = 1'b1;
                ctrl_o.soh_op = (opcode_i == OP_EXTRU) ? SOH_EXTRU :
                                (opcode_i == OP_EXTRS) ? SOH_EXTRS : SOH_ZDEP;
            end
            OP_COMBT, OP_COMBF: begin
                ctrl_o.b      = 1'b1;
                ctrl_o.alu_op = ALU_CMP;
                ctrl_o.id_sr  = IDSR_COMB;
            end
            OP_BL: begin
                ctrl_o.srd   = SRD_R1;
                ctrl_o.ub    = 1'b1;
                ctrl_o.rf_le = 1'b1;
            end
            default: ctrl_o = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/cpu_pipeline.sv
// Fetch/decode front-end with IF/ID and EX/MEM/WB control registers; the ROM
// contents come from the ROM_IMAGE parameter (byte address = outer index).
module cpu_pipeline
    import cpu_pipeline_pkg::*;
#(
    parameter rom_image_t ROM_IMAGE = ROM_EMPTY
) (
    input  logic          Clk,
    input  logic          Rst,
    cpu_pipeline_if.slave bus
);

    logic [7:0]   pc_q, pc_d;
    logic [31:0]  ifid_q, ifid_d;
    logic [31:0]  fetch_word;
    ctrl_bundle_t dec_ctrl, id_ctrl;
    ctrl_bundle_t idex_q, idex_d;
    mem_ctrl_t    exmem_q, exmem_d;
    logic         memwb_q, memwb_d;

    // Big-endian word fetch; the byte offsets wrap inside the 8-bit space
    always_comb begin
        fetch_word = {ROM_IMAGE[pc_q],
                      ROM_IMAGE[pc_q + 8'd1],
                      ROM_IMAGE[pc_q + 8'd2],
                      ROM_IMAGE[pc_q + 8'd3]};
    end

    cpu_control_unit u_ctrl (
        .opcode_i (ifid_q[31:26]),
        .func_i   (ifid_q[11:6]),
        .ctrl_o   (dec_ctrl)
    );

    always_comb begin
        pc_d    = bus.LE ? pc_q + 8'd4 : pc_q;
        ifid_d  = bus.LE ? fetch_word : ifid_q;
        id_ctrl = bus.S ? CTRL_NOP : dec_ctrl;
        // Downstream stages advance every cycle, independent of LE
        idex_d  = id_ctrl;
        exmem_d = '{ram_ctrl: idex_q.ram_ctrl, l: idex_q.l, rf_le: idex_q.rf_le};
        memwb_d = exmem_q.rf_le;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            pc_q    <= '0;
            ifid_q  <= '0;
            idex_q  <= CTRL_NOP;
            exmem_q <= '0;
            memwb_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign bus.front_q_out     = pc_q;
    assign bus.instruction_out = ifid_q;

    assign bus.SRD_out       = id_ctrl.srd;
    assign bus.PSW_LE_RE_out = id_ctrl.psw_le_re;
    assign bus.B_out         = id_ctrl.b;
    assign bus.SOH_OP_out    = id_ctrl.soh_op;
    assign bus.ALU_OP_out    = id_ctrl.alu_op;
    assign bus.RAM_CTRL_out  = id_ctrl.ram_ctrl;
    assign bus.L_out         = id_ctrl.l;
    assign bus.RF_LE_out     = id_ctrl.rf_le;
    assign bus.ID_SR_out     = id_ctrl.id_sr;
    assign bus.UB_out        = id_ctrl.ub;

    assign bus.SRD_EX_out       = idex_q.srd;
    assign bus.PSW_LE_RE_EX_out = idex_q.psw_le_re;
    assign bus.B_EX_out         = idex_q.b;
    assign bus.SOH_OP_EX_out    = idex_q.soh_op;
    assign bus.ALU_OP_EX_out    = idex_q.alu_op;
    assign bus.RAM_CTRL_EX_out  = idex_q.ram_ctrl;
    assign bus.L_EX_out         = idex_q.l;
    assign bus.RF_LE_EX_out     = idex_q.rf_le;
    assign bus.ID_SR_EX_out     = idex_q.id_sr;
    assign bus.UB_EX_out        = idex_q.ub;

    assign bus.RAM_CTRL_MEM_out = exmem_q.ram_ctrl;
    assign bus.L_MEM_out        = exmem_q.l;
    assign bus.RF_LE_MEM_out    = exmem_q.rf_le;
    assign bus.RF_LE_WB_out     = memwb_q;

endmodule

// File: tb/tb_cpu_pipeline.sv
// Directed bench for cpu_pipeline: small program in the ROM, hand-computed
// control bundles checked at ID, EX, MEM and WB.
module tb_cpu_pipeline;

    typedef logic [255:0][7:0] img_t;

    // Program: word address -> encoding
    function automatic img_t build_img();
        img_t img;
        logic [31:0] w [9];
        logic [7:0]  a [9];
        img = '0;
        w[0] = 32'h08A2_0603; a[0] = 8'd0;    // ADD  (func 0x18)
        w[1] = 32'h4800_0000; a[1] = 8'd4;    // LDW
        w[2] = 32'h8000_0000; a[2] = 8'd8;    // COMBT
        w[3] = 32'hE800_0000; a[3] = 8'd12;   // BL
        w[4] = 32'h6800_0000; a[4] = 8'd16;   // STW
        w[5] = 32'h0800_0700; a[5] = 8'd20;   // ADDC (func 0x1C)
        w[6] = 32'hFC00_0000; a[6] = 8'd24;   // unknown opcode 0x3F
        w[7] = 32'h2000_0000; a[7] = 8'd28;   // LDIL
        w[8] = 32'hD000_0000; a[8] = 8'd252;  // EXTRU
        for (int i = 0; i < 9; i++) begin
            img[a[i]]        = w[i][31:24];
            img[a[i] + 8'd1] = w[i][23:16];
            img[a[i] + 8'd2] = w[i][15:8];
            img[a[i] + 8'd3] = w[i][7:0];
        end
        return img;
    endfunction

    localparam img_t IMG = build_img();

    // {SRD, PSW_LE_RE, B, SOH_OP, ALU_OP, RAM_CTRL, L, RF_LE, ID_SR, UB}
    localparam logic [20:0] B_NOP   = 21'd0;
    localparam logic [20:0] B_ADD   = {2'b00, 2'b10, 1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b0};
    localparam logic [20:0] B_LDW   = {2'b01, 2'b00, 1'b0, 3'b010, 4'b0000, 4'b1010, 1'b1, 1'b1, 2'b00, 1'b0};
    localparam logic [20:0] B_COMBT = {2'b00, 2'b00, 1'b1, 3'b000, 4'b1001, 4'b0000, 1'b0, 1'b0, 2'b10, 1'b0};
    localparam logic [20:0] B_BL    = {2'b10, 2'b00, 1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b1};
    localparam logic [20:0] B_STW   = {2'b00, 2'b00, 1'b0, 3'b010, 4'b0000, 4'b1110, 1'b0, 1'b0, 2'b01, 1'b0};
    localparam logic [20:0] B_ADDC  = {2'b00, 2'b11, 1'b0, 3'b000, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b0};
    localparam logic [20:0] B_LDIL  = {2'b10, 2'b00, 1'b0, 3'b011, 4'b1000, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b0};
    localparam logic [20:0] B_EXTRU = {2'b01, 2'b00, 1'b0, 3'b100, 4'b1000, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b0};

    // {RAM_CTRL, L, RF_LE} at MEM
    localparam logic [5:0] M_ADD = 6'b0000_0_1;
    localparam logic [5:0] M_LDW = 6'b1010_1_1;
    localparam logic [5:0] M_NO  = 6'b0000_0_0;
    localparam logic [5:0] M_STW = 6'b1110_0_0;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    cpu_pipeline_if bus ();

    cpu_pipeline #(.ROM_IMAGE(IMG)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] id_obs();
        return {bus.SRD_out, bus.PSW_LE_RE_out, bus.B_out, bus.SOH_OP_out, bus.ALU_OP_out,
                bus.RAM_CTRL_out, bus.L_out, bus.RF_LE_out, bus.ID_SR_out, bus.UB_out};
    endfunction

    function automatic logic [20:0] ex_obs();
        return {bus.SRD_EX_out, bus.PSW_LE_RE_EX_out, bus.B_EX_out, bus.SOH_OP_EX_out,
                bus.ALU_OP_EX_out, bus.RAM_CTRL_EX_out, bus.L_EX_out, bus.RF_LE_EX_out,
                bus.ID_SR_EX_out, bus.UB_EX_out};
    endfunction

    function automatic logic [5:0] mem_obs();
        return {bus.RAM_CTRL_MEM_out, bus.L_MEM_out, bus.RF_LE_MEM_out};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver: advance one edge, settle outputs away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stage(input string tag, input logic [7:0] pc, input logic [31:0] ins,
                               input logic [20:0] id_b, input logic [20:0] ex_b);
        check_eq({tag, ".pc"},    {24'd0, bus.front_q_out}, {24'd0, pc});
        check_eq({tag, ".instr"}, bus.instruction_out, ins);
        check_eq({tag, ".id"},    {11'd0, id_obs()}, {11'd0, id_b});
        check_eq({tag, ".ex"},    {11'd0, ex_obs()}, {11'd0, ex_b});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus.LE = 1'b1;
        bus.S  = 1'b0;

        tick();
        check_stage("reset", 8'd0, 32'd0, B_NOP, B_NOP);
        check_eq("reset.mem", {26'd0, mem_obs()}, {26'd0, M_NO});
        check_eq("reset.wb",  {31'd0, bus.RF_LE_WB_out}, 32'd0);

        rst = 1'b1;
        tick();
        check_stage("f1", 8'd4, 32'h08A2_0603, B_ADD, B_NOP);
        tick();
        check_stage("f2", 8'd8, 32'h4800_0000, B_LDW, B_ADD);
        tick();
        check_stage("f3", 8'd12, 32'h8000_0000, B_COMBT, B_LDW);
        check_eq("f3.mem", {26'd0, mem_obs()}, {26'd0, M_ADD});
        tick();
        check_stage("f4", 8'd16, 32'hE800_0000, B_BL, B_COMBT);
        check_eq("f4.mem", {26'd0, mem_obs()}, {26'd0, M_LDW});
        check_eq("f4.wb",  {31'd0, bus.RF_LE_WB_out}, 32'd1);
        tick();
        check_stage("f5", 8'd20, 32'h6800_0000, B_STW, B_BL);
        check_eq("f5.mem", {26'd0, mem_obs()}, {26'd0, M_NO});
        check_eq("f5.wb",  {31'd0, bus.RF_LE_WB_out}, 32'd1);

        // freeze on STW
        bus.LE = 1'b0;
        tick();
        check_stage("frz1", 8'd20, 32'h6800_0000, B_STW, B_STW);
        tick();
        check_stage("frz2", 8'd20, 32'h6800_0000, B_STW, B_STW);
        check_eq("frz2.mem", {26'd0, mem_obs()}, {26'd0, M_STW});

        bus.LE = 1'b1;
        tick();
        check_stage("run", 8'd24, 32'h0800_0700, B_ADDC, B_STW);

        // NOP insert over ADDC
        bus.S = 1'b1;
        #1;
        check_eq("nop.id_now", {11'd0, id_obs()}, {11'd0, B_NOP});
        tick();
        check_stage("nop1", 8'd28, 32'hFC00_0000, B_NOP, B_NOP);
        bus.S = 1'b0;
        #1;
        check_eq("unknown.id", {11'd0, id_obs()}, {11'd0, B_NOP});
        tick();
        check_stage("nop2", 8'd32, 32'h2000_0000, B_LDIL, B_NOP);
        check_eq("nop2.mem", {26'd0, mem_obs()}, {26'd0, M_NO});

        // S=1 while frozen on LDIL
        bus.LE = 1'b0;
        bus.S  = 1'b1;
        tick();
        check_stage("frzs", 8'd32, 32'h2000_0000, B_NOP, B_NOP);
        check_eq("nop3.wb", {31'd0, bus.RF_LE_WB_out}, 32'd0);
        bus.S = 1'b0;
        tick();
        check_stage("frzr", 8'd32, 32'h2000_0000, B_LDIL, B_LDIL);

        // run to PC wrap: word at 252 is fetched as PC rolls to 0
        bus.LE = 1'b1;
        for (int i = 0; i < 56; i++) tick();
        check_stage("wrap", 8'd0, 32'hD000_0000, B_EXTRU, B_NOP);
        tick();
        check_stage("wrap1", 8'd4, 32'h08A2_0603, B_ADD, B_EXTRU);

        // mid-run reset
        rst = 1'b0;
        tick();
        check_stage("rst2", 8'd0, 32'd0, B_NOP, B_NOP);
        check_eq("rst2.mem", {26'd0, mem_obs()}, {26'd0, M_NO});
        check_eq("rst2.wb",  {31'd0, bus.RF_LE_WB_out}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
